// File: rtl/rr_channel_mux_pkg.sv
// Shared definitions for the round-robin channel multiplexer.
// Optional statistics counter is enabled with macro RR_CHANNEL_MUX_STATS_EN.
package rr_channel_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int CNT_W = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Saturating increment for the transfer counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority finder: returns the first set request at or after
// the start index, scanning upward modulo N.
module rr_priority_pick #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] start,
  output logic            found,
  output logic [SELW-1:0] idx
);

  // Walk the N positions starting at start; the first requester wins.
  always_comb begin
    int   pos;
    logic hit;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos   = (int'(start) + k) % N;
      hit   = !found && req[pos];
      found = found | hit;
      idx   = hit ? SELW'(pos) : idx;
    end
  end

endmodule

// File: rtl/rr_channel_mux.sv
// N:1 channel multiplexer with manual or round-robin selection and a
// registered valid/ready output stage.
// Optional macro RR_CHANNEL_MUX_STATS_EN adds clr_count / xfer_count.
module rr_channel_mux
  import rr_channel_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef RR_CHANNEL_MUX_STATS_EN
  input  logic               clr_count,
  output logic [CNT_W-1:0]   xfer_count,
`endif
  output logic [SELW-1:0]    out_chan
);

  out_state_e       state_r;
  out_state_e       state_nxt_s;
  logic [SELW-1:0]  rr_ptr_r;
  logic [SELW-1:0]  rr_ptr_nxt_s;
  logic [WIDTH-1:0] data_r;
  logic [SELW-1:0]  chan_r;

  logic             rr_found_s;
  logic [SELW-1:0]  rr_idx_s;
  logic             grant_s;
  logic [SELW-1:0]  gnt_idx_s;
  logic [WIDTH-1:0] gnt_word_s;
  logic             load_s;
  logic             xfer_s;

  rr_priority_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req   (in_valid),
    .start (rr_ptr_r),
    .found (rr_found_s),
    .idx   (rr_idx_s)
  );

  // Output register may take a new word when empty or draining this cycle;
  // in_ready is forced low while reset is held.
  assign load_s = (state_r == OUT_EMPTY) || out_ready;
  assign xfer_s = rst_n && load_s && grant_s;

  // Arbitration: pick the candidate channel and its data word.
  always_comb begin
    grant_s    = 1'b0;
    gnt_idx_s  = '0;
    gnt_word_s = '0;
    if (mode == MODE_RR) begin
      grant_s   = rr_found_s;
      gnt_idx_s = rr_idx_s;
    end else begin
      gnt_idx_s = sel;
      if (int'(sel) < N) begin
        grant_s = in_valid[sel];
      end else begin
        grant_s = 1'b0;
      end
    end
    if (grant_s) begin
      gnt_word_s = in_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
    end else begin
      gnt_word_s = '0;
    end
  end

  // Pointer advances past the granted channel, wrapping N-1 to 0.
  assign rr_ptr_nxt_s = (int'(gnt_idx_s) == N - 1) ? '0 : gnt_idx_s + SELW'(1);

  // Next-state logic for the output register full/empty bit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      OUT_EMPTY: state_nxt_s = grant_s ? OUT_FULL : OUT_EMPTY;
      OUT_FULL: begin
        if (out_ready) begin
          state_nxt_s = grant_s ? OUT_FULL : OUT_EMPTY;
        end else begin
          state_nxt_s = OUT_FULL;
        end
      end
      default: state_nxt_s = OUT_EMPTY;
    endcase
  end

  // State, held word, channel tag and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= OUT_EMPTY;
      data_r   <= '0;
      chan_r   <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (xfer_s) begin
        data_r <= gnt_word_s;
        chan_r <= gnt_idx_s;
      end else begin
        data_r <= data_r;
        chan_r <= chan_r;
      end
      if (xfer_s && (mode == MODE_RR)) begin
        rr_ptr_r <= rr_ptr_nxt_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Output decode: one-hot accept strobe towards the granted producer.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer_s && (int'(gnt_idx_s) == i);
    end
  end

  assign out_valid = (state_r == OUT_FULL);
  assign out_data  = data_r;
  assign out_chan  = chan_r;

`ifdef RR_CHANNEL_MUX_STATS_EN
  logic [CNT_W-1:0] cnt_r;

  // Transfer counter: clear wins over a simultaneous transfer; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr_count) begin
      cnt_r <= '0;
    end else if (xfer_s) begin
      cnt_r <= sat_inc(cnt_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign xfer_count = cnt_r;
`endif

endmodule

// File: tb/tb_rr_channel_mux.sv
// Directed self-checking bench for rr_channel_mux (N=4, WIDTH=4).
// Stats tests run only when RR_CHANNEL_MUX_STATS_EN is defined.
module tb_rr_channel_mux;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;
`ifdef RR_CHANNEL_MUX_STATS_EN
  logic        clr_count;
  logic [15:0] xfer_count;
`endif

  int checks = 0;
  int errors = 0;

  rr_channel_mux #(.WIDTH(4), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef RR_CHANNEL_MUX_STATS_EN
    .clr_count (clr_count),
    .xfer_count(xfer_count),
`endif
    .out_chan  (out_chan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0;
    in_data = 16'h0000; in_valid = 4'b1111; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", out_valid); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_data got %h expected 0", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan got %0d expected 0", out_chan); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b expected 0000", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL release_in_ready got %b expected 0001", in_ready); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_manual();
    logic [3:0] exp_w;
    logic [3:0] exp_rdy;
    mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) in_data[i*4 +: 4] = 4'(p*4 + i);
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        exp_w = 4'(p*4 + s);
        exp_rdy = 4'b0001 << s;
        #1;
        checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL manual_ready p=%0d sel=%0d got %b expected %b", p, s, in_ready, exp_rdy); end
        tick();
        checks++; if (out_data !== exp_w) begin errors++; $display("FAIL manual_data p=%0d sel=%0d got %h expected %h", p, s, out_data, exp_w); end
        checks++; if (out_chan !== 2'(s)) begin errors++; $display("FAIL manual_chan p=%0d sel=%0d got %0d expected %0d", p, s, out_chan, s); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL manual_valid p=%0d sel=%0d got %b expected 1", p, s, out_valid); end
      end
    end
  endtask

  task automatic test_rr_fairness();
    logic [3:0] exp_d [5];
    logic [1:0] exp_c [5];
    exp_d = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    mode = 1'b1; in_valid = 4'b1111; in_data = 16'hDCBA; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (out_data !== exp_d[k]) begin errors++; $display("FAIL rr_data step=%0d got %h expected %h", k, out_data, exp_d[k]); end
      checks++; if (out_chan !== exp_c[k]) begin errors++; $display("FAIL rr_chan step=%0d got %0d expected %0d", k, out_chan, exp_c[k]); end
    end
  endtask

  task automatic test_reset_mid_transfer();
    tick();
    checks++; if (out_chan !== 2'd1) begin errors++; $display("FAIL pre_reset_chan got %0d expected 1", out_chan); end
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b expected 0", out_valid); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL midrst_data got %h expected 0", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL midrst_chan got %0d expected 0", out_chan); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL midrst_in_ready got %b expected 0000", in_ready); end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL post_reset_chan got %0d expected 0", out_chan); end
    checks++; if (out_data !== 4'hA) begin errors++; $display("FAIL post_reset_data got %h expected a", out_data); end
  endtask

  task automatic test_sparse();
    logic [1:0] exp_c [4];
    logic [3:0] exp_d [4];
    exp_c = '{2'd1, 2'd3, 2'd1, 2'd3};
    exp_d = '{4'h2, 4'h4, 4'h2, 4'h4};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode = 1'b1; in_valid = 4'b1010; in_data = 16'h4321; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_chan !== exp_c[k]) begin errors++; $display("FAIL sparse_chan step=%0d got %0d expected %0d", k, out_chan, exp_c[k]); end
      checks++; if (out_data !== exp_d[k]) begin errors++; $display("FAIL sparse_data step=%0d got %h expected %h", k, out_data, exp_d[k]); end
    end
    in_valid = 4'b0000;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL idle_in_ready got %b expected 0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b expected 0", out_valid); end
    checks++; if (out_data !== 4'h4) begin errors++; $display("FAIL idle_data_hold got %h expected 4", out_data); end
    checks++; if (out_chan !== 2'd3) begin errors++; $display("FAIL idle_chan_hold got %0d expected 3", out_chan); end
  endtask

  task automatic test_backpressure();
    mode = 1'b1; in_valid = 4'b1111; in_data = 16'h8765; out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 4'h5) begin errors++; $display("FAIL bp_first_data got %h expected 5", out_data); end
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready got %b expected 0000", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got %b expected 1", k, out_valid); end
      checks++; if (out_data !== 4'h5) begin errors++; $display("FAIL bp_data cyc=%0d got %h expected 5", k, out_data); end
      checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL bp_chan cyc=%0d got %0d expected 0", k, out_chan); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready cyc=%0d got %b expected 0000", k, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b expected 0010", in_ready); end
    tick();
    checks++; if (out_data !== 4'h6) begin errors++; $display("FAIL bp_release_data got %h expected 6", out_data); end
    checks++; if (out_chan !== 2'd1) begin errors++; $display("FAIL bp_release_chan got %0d expected 1", out_chan); end
  endtask

  task automatic test_mode_switch();
    mode = 1'b0; sel = 2'd3;
    tick();
    checks++; if (out_chan !== 2'd3) begin errors++; $display("FAIL switch_manual_chan got %0d expected 3", out_chan); end
    checks++; if (out_data !== 4'h8) begin errors++; $display("FAIL switch_manual_data got %h expected 8", out_data); end
    mode = 1'b1;
    tick();
    checks++; if (out_chan !== 2'd2) begin errors++; $display("FAIL switch_rr_chan got %0d expected 2", out_chan); end
    checks++; if (out_data !== 4'h7) begin errors++; $display("FAIL switch_rr_data got %h expected 7", out_data); end
  endtask

`ifdef RR_CHANNEL_MUX_STATS_EN
  task automatic test_stats();
    clr_count = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (xfer_count !== 16'h0000) begin errors++; $display("FAIL stats_reset got %h expected 0000", xfer_count); end
    rst_n = 1'b1;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    repeat (70000) tick();
    checks++; if (xfer_count !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate got %h expected ffff", xfer_count); end
    clr_count = 1'b1;
    tick();
    checks++; if (xfer_count !== 16'h0000) begin errors++; $display("FAIL stats_clear got %h expected 0000", xfer_count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stats_clear_xfer got %b expected 1", out_valid); end
    clr_count = 1'b0;
    tick();
    checks++; if (xfer_count !== 16'h0001) begin errors++; $display("FAIL stats_after_clear got %h expected 0001", xfer_count); end
  endtask
`endif

  initial begin
`ifdef RR_CHANNEL_MUX_STATS_EN
    clr_count = 1'b0;
`endif
    test_reset();
    test_manual();
    test_rr_fairness();
    test_reset_mid_transfer();
    test_sparse();
    test_backpressure();
    test_mode_switch();
`ifdef RR_CHANNEL_MUX_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
